counter_down_mod: RTL and testbench

Parametrised modulo-N down-counter digit for the timer datapath. It is the general successor to the fixed mod-10 digit: configurable width and modulus, a run-time reload value on borrow, and a one-shot/wrap mode. Digits cascade by tying a higher digit's enablen to the lower digit's rco_L, for example to build MM:SS from mod-10 and mod-6 instances. A done pulse signals terminal count to the timer control FSM.

---
 rtl/counter_down_mod.sv | 115 +++++++++++
 tb/tb_counter_down_mod.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_down_mod.sv
// -----------------------------------------------------------------------------
// counter_down_mod
// Parametrised modulo-N down-counter digit for the timer datapath.
//
// Counts MODULUS-1 .. 0. On a borrow from 0 it either wraps to a run-time
// reload value or, in one-shot mode, stays at 0. Digits cascade by tying a
// higher digit's enablen to the lower digit's rco_L. The cascade is purely
// combinational, so every digit of a chain steps on the same clock edge.
//
// Parameters:
//   WIDTH    - bit width of count / in / reload_val
//   MODULUS  - counting range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active-low
//   enablen     in   count enable, active-low (cascade input)
//   load        in   synchronous preset, active-high, beats enablen
//   oneshot     in   1 = stop at 0, 0 = wrap to reload_val on borrow
//   in          in   preset value used by load
//   reload_val  in   value taken on borrow from 0 in wrap mode
//   count       out  current digit value, registered
//   rco_L       out  ripple borrow, active-low, combinational
//   zero        out  count == 0, combinational
//   done        out  one-cycle registered pulse on decrement 1 -> 0
//
// Build option:
//   COUNTER_DOWN_MOD_CLAMP_EN - defined: out-of-range in/reload_val clamp to
//                               MODULUS-1; undefined: they become 0.
// -----------------------------------------------------------------------------
module counter_down_mod #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enablen,
   input  logic             load,
   input  logic             oneshot,
   input  logic [WIDTH-1:0] in,
   input  logic [WIDTH-1:0] reload_val,
   output logic [WIDTH-1:0] count,
   output logic             rco_L,
   output logic             zero,
   output logic             done
);

   // Reject moduli that cannot be represented or cannot count.
   generate
      if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
         $error("counter_down_mod: MODULUS=%0d illegal for WIDTH=%0d", MODULUS, WIDTH);
      end
   endgenerate

   // MODULUS may equal 2**WIDTH, so the comparison is done one bit wider.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

`ifdef COUNTER_DOWN_MOD_CLAMP_EN
   localparam logic [WIDTH-1:0] OOR_VAL = WIDTH'(MODULUS - 1);
`else
   localparam logic [WIDTH-1:0] OOR_VAL = '0;
`endif

   // Keeps any externally supplied value inside 0..MODULUS-1.
   function automatic logic [WIDTH-1:0] sat(input logic [WIDTH-1:0] v);
      sat = ({1'b0, v} < MOD_EXT) ? v : OOR_VAL;
   endfunction

   logic [WIDTH-1:0] r_count;
   logic             r_done;
   logic [WIDTH-1:0] w_count_next;
   logic             w_done_next;
   logic             w_zero;
   logic [WIDTH-1:0] w_in_sat;
   logic [WIDTH-1:0] w_reload_sat;

   assign w_zero       = (r_count == '0);
   assign w_in_sat     = sat(in);
   assign w_reload_sat = sat(reload_val);

   // Next-state: load > hold > decrement > wrap/stop.
   always_comb begin
      w_count_next = r_count;
      w_done_next  = 1'b0;
      if (load) begin
         w_count_next = w_in_sat;
      end else if (!enablen) begin
         if (!w_zero) begin
            w_count_next = r_count - ONE;
            w_done_next  = (r_count == ONE);
         end else if (!oneshot) begin
            w_count_next = w_reload_sat;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         r_count <= w_count_next;
         r_done  <= w_done_next;
      end
   end

   // A borrow is only issued when this digit actually wraps on this edge:
   // a pending load or a one-shot stop at 0 must not ripple upstream.
   assign rco_L = ~(w_zero & ~enablen & ~load & ~oneshot);
   assign zero  = w_zero;
   assign count = r_count;
   assign done  = r_done;

endmodule

// File: tb/tb_counter_down_mod.sv
// -----------------------------------------------------------------------------
// tb_counter_down_mod
// Self-checking bench for counter_down_mod: a directed vector table on a
// mod-10 digit, a mod-6 out-of-range sequence, a mod-6/mod-10 cascade
// countdown from 50 with wrap, and asynchronous reset mid-count.
// -----------------------------------------------------------------------------
module tb_counter_down_mod;

`ifdef COUNTER_DOWN_MOD_CLAMP_EN
   localparam logic [3:0] S10 = 4'd9;   // sanitised out-of-range value, mod 10
   localparam logic [3:0] S6  = 4'd5;   // sanitised out-of-range value, mod 6
`else
   localparam logic [3:0] S10 = 4'd0;
   localparam logic [3:0] S6  = 4'd0;
`endif

   logic clk;
   logic rst_n;

   // mod-10 digit under table test
   logic       a_load, a_en_n, a_os;
   logic [3:0] a_din, a_rld, a_cnt;
   logic       a_rco, a_zero, a_done;

   // mod-6 digit for out-of-range tests
   logic       b_load, b_en_n, b_os;
   logic [3:0] b_din, b_rld, b_cnt;
   logic       b_rco, b_zero, b_done;

   // cascade: units mod-10, tens mod-6
   logic       c_load, c_en_n;
   logic [3:0] c_u_din, c_u_cnt;
   logic [2:0] c_t_din, c_t_cnt;
   logic       c_u_rco, c_u_zero, c_u_done;
   logic       c_t_rco, c_t_zero, c_t_done;

   int checks   = 0;
   int failures = 0;

   counter_down_mod #(.WIDTH(4), .MODULUS(10)) u_dut10 (
      .clk(clk), .rst(rst_n), .enablen(a_en_n), .load(a_load), .oneshot(a_os),
      .in(a_din), .reload_val(a_rld), .count(a_cnt), .rco_L(a_rco),
      .zero(a_zero), .done(a_done)
   );

   counter_down_mod #(.WIDTH(4), .MODULUS(6)) u_dut6 (
      .clk(clk), .rst(rst_n), .enablen(b_en_n), .load(b_load), .oneshot(b_os),
      .in(b_din), .reload_val(b_rld), .count(b_cnt), .rco_L(b_rco),
      .zero(b_zero), .done(b_done)
   );

   counter_down_mod #(.WIDTH(4), .MODULUS(10)) u_units (
      .clk(clk), .rst(rst_n), .enablen(c_en_n), .load(c_load), .oneshot(1'b0),
      .in(c_u_din), .reload_val(4'd9), .count(c_u_cnt), .rco_L(c_u_rco),
      .zero(c_u_zero), .done(c_u_done)
   );

   counter_down_mod #(.WIDTH(3), .MODULUS(6)) u_tens (
      .clk(clk), .rst(rst_n), .enablen(c_u_rco), .load(c_load), .oneshot(1'b0),
      .in(c_t_din), .reload_val(3'd5), .count(c_t_cnt), .rco_L(c_t_rco),
      .zero(c_t_zero), .done(c_t_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic       rst_n;
      logic       load;
      logic       en_n;
      logic       os;
      logic [3:0] din;
      logic [3:0] rld;
      logic       exp_rco;   // rco_L after inputs applied, before the edge
      logic [3:0] exp_cnt;   // count after the edge
      logic       exp_done;  // done after the edge
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic r, input logic l, input logic e, input logic o,
                               input logic [3:0] di, input logic [3:0] rl,
                               input logic er, input logic [3:0] ec, input logic ed);
      vec_t v;
      v.rst_n = r; v.load = l; v.en_n = e; v.os = o; v.din = di; v.rld = rl;
      v.exp_rco = er; v.exp_cnt = ec; v.exp_done = ed;
      return v;
   endfunction

   initial begin
      //              rst ld en os din rld  rco cnt done
      vecs[0]  = mk(0, 0, 0, 0, 0,  9,   0,  0,  0);  // reset, enablen=0 -> borrow
      vecs[1]  = mk(1, 1, 0, 0, 7,  9,   1,  7,  0);  // load beats enablen at 0
      vecs[2]  = mk(1, 0, 0, 0, 0,  9,   1,  6,  0);
      vecs[3]  = mk(1, 0, 0, 0, 0,  9,   1,  5,  0);
      vecs[4]  = mk(1, 0, 0, 0, 0,  9,   1,  4,  0);
      vecs[5]  = mk(1, 0, 0, 0, 0,  9,   1,  3,  0);
      vecs[6]  = mk(1, 0, 0, 0, 0,  9,   1,  2,  0);
      vecs[7]  = mk(1, 0, 0, 0, 0,  9,   1,  1,  0);
      vecs[8]  = mk(1, 0, 0, 0, 0,  9,   1,  0,  1);  // 1 -> 0 gives done
      vecs[9]  = mk(1, 0, 0, 0, 0,  9,   0,  9,  0);  // wrap, borrow out
      vecs[10] = mk(1, 0, 1, 0, 0,  9,   1,  9,  0);  // hold
      vecs[11] = mk(1, 1, 1, 1, 2,  9,   1,  2,  0);  // one-shot preset 2
      vecs[12] = mk(1, 0, 0, 1, 0,  9,   1,  1,  0);
      vecs[13] = mk(1, 0, 0, 1, 0,  9,   1,  0,  1);
      vecs[14] = mk(1, 0, 0, 1, 0,  9,   1,  0,  0);  // stopped, no borrow
      vecs[15] = mk(1, 0, 0, 1, 0,  9,   1,  0,  0);
      vecs[16] = mk(1, 0, 0, 0, 0,  4,   0,  4,  0);  // oneshot off -> wrap to 4
      vecs[17] = mk(1, 1, 1, 0, 10, 9,   1,  S10, 0); // in == MODULUS
      vecs[18] = mk(1, 1, 1, 0, 9,  9,   1,  9,  0);  // in == MODULUS-1
      vecs[19] = mk(1, 1, 1, 0, 0,  9,   1,  0,  0);
      vecs[20] = mk(1, 0, 0, 0, 0,  11,  0,  S10, 0); // reload out of range
      vecs[21] = mk(1, 0, 1, 0, 0,  11,  1,  S10, 0);

      rst_n = 1'b0;
      a_load = 0; a_en_n = 1; a_os = 0; a_din = 0; a_rld = 9;
      b_load = 0; b_en_n = 1; b_os = 0; b_din = 0; b_rld = 0;
      c_load = 0; c_en_n = 1; c_u_din = 0; c_t_din = 0;

      // ---------------- table on the mod-10 digit ----------------
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst_n  = vecs[i].rst_n;
         a_load = vecs[i].load;
         a_en_n = vecs[i].en_n;
         a_os   = vecs[i].os;
         a_din  = vecs[i].din;
         a_rld  = vecs[i].rld;
         #1;
         chk($sformatf("v%0d_rco_L", i), int'(a_rco), int'(vecs[i].exp_rco));
         @(posedge clk); #1;
         chk($sformatf("v%0d_count", i), int'(a_cnt), int'(vecs[i].exp_cnt));
         chk($sformatf("v%0d_done", i), int'(a_done), int'(vecs[i].exp_done));
         chk($sformatf("v%0d_zero", i), int'(a_zero), int'(vecs[i].exp_cnt == 4'd0));
         $display("vec %0d: count=%0d done=%0d rco_L=%0d", i, a_cnt, a_done, a_rco);
      end
      @(negedge clk);
      a_load = 0; a_en_n = 1;

      // ---------------- mod-6 out-of-range ----------------
      b_load = 1; b_din = 9;
      @(posedge clk); #1;
      chk("m6_in9", int'(b_cnt), int'(S6));
      @(negedge clk); b_din = 6;
      @(posedge clk); #1;
      chk("m6_in6", int'(b_cnt), int'(S6));
      @(negedge clk); b_din = 5;
      @(posedge clk); #1;
      chk("m6_in5", int'(b_cnt), 5);
      @(negedge clk); b_din = 0;
      @(posedge clk); #1;
      chk("m6_in0", int'(b_cnt), 0);
      @(negedge clk); b_load = 0; b_en_n = 0; b_rld = 9;
      #1;
      chk("m6_rco_wrap", int'(b_rco), 0);
      @(posedge clk); #1;
      chk("m6_reload9", int'(b_cnt), int'(S6));
      chk("m6_zero", int'(b_zero), int'(S6 == 4'd0));
      chk("m6_done", int'(b_done), 0);
      $display("mod6: reload 9 -> count=%0d", b_cnt);
      @(negedge clk); b_en_n = 1;

      // ---------------- cascade 50 -> 00 -> 59 ----------------
      c_load = 1; c_t_din = 3'd5; c_u_din = 4'd0;
      @(posedge clk); #1;
      chk("cas_preset", int'(c_t_cnt) * 10 + int'(c_u_cnt), 50);
      @(negedge clk); c_load = 0; c_en_n = 0;
      for (int k = 1; k <= 51; k++) begin
         int exp_v;
         exp_v = (k <= 50) ? 50 - k : 59;
         if (k == 51) begin
            chk("cas_tens_rco_at_00", int'(c_t_rco), 0);
         end
         @(posedge clk); #1;
         chk($sformatf("cas_step%0d", k), int'(c_t_cnt) * 10 + int'(c_u_cnt), exp_v);
         $display("cascade step %0d: %0d:%0d", k, c_t_cnt, c_u_cnt);
      end
      @(negedge clk); c_en_n = 1;

      // ---------------- asynchronous reset mid-count ----------------
      a_load = 1; a_din = 4; a_en_n = 1;
      @(posedge clk); #1;
      chk("rst_pre_count", int'(a_cnt), 4);
      #2 rst_n = 1'b0;          // clock high, no edge pending
      #1;
      chk("rst_async_count", int'(a_cnt), 0);
      chk("rst_async_zero", int'(a_zero), 1);
      @(negedge clk);
      rst_n = 1'b1; a_load = 1; a_din = 1;
      @(posedge clk); #1;
      chk("rst2_load1", int'(a_cnt), 1);
      @(negedge clk); a_load = 0; a_en_n = 0;
      @(posedge clk); #1;
      chk("rst2_done_pulse", int'(a_done), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst2_done_cleared", int'(a_done), 0);
      $display("reset mid-count: count=%0d done=%0d", a_cnt, a_done);
      @(negedge clk); rst_n = 1'b1; a_en_n = 1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
